// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: handshakes an op into the external combinational ALU,
// captures its result and flags one cycle later, evaluates a branch condition and owns the PSW.
module alu_exec_ctrl #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_op,
    input  logic [SIZE-1:0] req_a,
    input  logic [SIZE-1:0] req_b,
    input  logic [2:0]      req_cond,
    input  logic            req_cond_src,
    input  logic            req_set_flags,
    output logic [3:0]      OP,
    output logic [SIZE-1:0] A,
    output logic [SIZE-1:0] B,
    input  logic [SIZE-1:0] F,
    input  logic            ZF,
    input  logic            CF,
    input  logic            OF,
    input  logic            SF,
    input  logic            PF,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [SIZE-1:0] resp_f,
    output logic [4:0]      resp_flags,
    output logic            resp_taken,
    output logic            resp_err,
    output logic [4:0]      psw
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] OP_SUB = 4'b0101;

    state_e          state_q, state_d;
    logic [3:0]      op_q;
    logic            illegal_q;
    logic [SIZE-1:0] a_q, b_q;
    logic [2:0]      cond_q;
    logic            cond_src_q;
    logic            set_flags_q;
    logic [SIZE-1:0] resp_f_q;
    logic [4:0]      resp_flags_q;
    logic            resp_taken_q;
    logic            resp_err_q;
    logic [4:0]      psw_q;

    logic            req_ready_s;
    logic            accept_s;
    logic            vf_s;
    logic [4:0]      alu_flags_s;
    logic            taken_s;

    // Flag vector layout is {Z, C, V, S, P}.
    function automatic logic cond_eval(input logic [2:0] cond, input logic [4:0] fl);
        logic r;
        case (cond)
            3'b000:  r = 1'b0;
            3'b001:  r = 1'b1;
            3'b010:  r = fl[4];
            3'b011:  r = ~fl[4];
            3'b100:  r = fl[1] ^ fl[2];
            3'b101:  r = ~(fl[1] ^ fl[2]);
            3'b110:  r = ~fl[3];
            3'b111:  r = fl[3];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Handshake FSM next-state and request-ready decode.
    always_comb begin
        state_d     = state_q;
        req_ready_s = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_s = 1'b1;
                if (req_valid) state_d = EXEC;
                else           state_d = IDLE;
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (resp_ready) begin
                    req_ready_s = 1'b1;
                    if (req_valid) state_d = EXEC;
                    else           state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The ALU computes OF against the uninverted B, so a subtract needs it flipped.
    always_comb begin
        vf_s        = (op_q == OP_SUB) ? ~OF : OF;
        alu_flags_s = {ZF, CF, vf_s, SF, PF};
        taken_s     = cond_eval(cond_q, cond_src_q ? psw_q : alu_flags_s);
    end

    assign accept_s = req_valid & req_ready_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Request capture, response capture and PSW update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= 4'b0000;
            illegal_q    <= 1'b0;
            a_q          <= {SIZE{1'b0}};
            b_q          <= {SIZE{1'b0}};
            cond_q       <= 3'b000;
            cond_src_q   <= 1'b0;
            set_flags_q  <= 1'b0;
            resp_f_q     <= {SIZE{1'b0}};
            resp_flags_q <= 5'b00000;
            resp_taken_q <= 1'b0;
            resp_err_q   <= 1'b0;
            psw_q        <= 5'b00000;
        end else begin
            if (accept_s) begin
                op_q        <= req_op[3] ? 4'b0000 : req_op;
                illegal_q   <= req_op[3];
                a_q         <= req_a;
                b_q         <= req_b;
                cond_q      <= req_cond;
                cond_src_q  <= req_cond_src;
                set_flags_q <= req_set_flags;
            end
            if (state_q == EXEC) begin
                if (illegal_q) begin
                    resp_f_q     <= {SIZE{1'b0}};
                    resp_flags_q <= 5'b00000;
                    resp_taken_q <= 1'b0;
                    resp_err_q   <= 1'b1;
                end else begin
                    resp_f_q     <= F;
                    resp_flags_q <= alu_flags_s;
                    resp_taken_q <= taken_s;
                    resp_err_q   <= 1'b0;
                    if (set_flags_q) psw_q <= alu_flags_s;
                end
            end
        end
    end

    assign req_ready  = req_ready_s;
    assign resp_valid = (state_q == RESP);
    assign OP         = op_q;
    assign A          = a_q;
    assign B          = b_q;
    assign resp_f     = resp_f_q;
    assign resp_flags = resp_flags_q;
    assign resp_taken = resp_taken_q;
    assign resp_err   = resp_err_q;
    assign psw        = psw_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl: a behavioural ALU drives F/flags, a reference model
// predicts each response at issue time and a monitor compares when the DUT retires it.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [2:0]  req_cond;
    logic        req_cond_src, req_set_flags;
    logic [3:0]  OP;
    logic [31:0] A, B, F;
    logic        ZF, CF, OF, SF, PF;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_f;
    logic [4:0]  resp_flags;
    logic        resp_taken, resp_err;
    logic [4:0]  psw;

    typedef struct {
        logic [31:0] f;
        logic [4:0]  flags;
        logic        taken;
        logic        err;
        logic [4:0]  psw;
        logic [3:0]  op_drv;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    logic [4:0] mpsw = 5'd0;
    int         rr_mode = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.SIZE(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cond(req_cond),
        .req_cond_src(req_cond_src), .req_set_flags(req_set_flags),
        .OP(OP), .A(A), .B(B), .F(F),
        .ZF(ZF), .CF(CF), .OF(OF), .SF(SF), .PF(PF),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_f(resp_f),
        .resp_flags(resp_flags), .resp_taken(resp_taken), .resp_err(resp_err),
        .psw(psw)
    );

    // External ALU: OF is computed against the uninverted B, so for SUB it is the
    // complement of true overflow.
    always_comb begin
        logic [32:0] s;
        F  = 32'd0;
        CF = 1'b0;
        OF = 1'b0;
        s  = 33'd0;
        case (OP)
            4'd0: F = A & B;
            4'd1: F = A | B;
            4'd2: F = A ^ B;
            4'd3: F = ~(A | B);
            4'd4: begin
                s  = {1'b0, A} + {1'b0, B};
                F  = s[31:0];
                CF = s[32];
                OF = (A[31] == B[31]) && (F[31] != A[31]);
            end
            4'd5: begin
                F  = A - B;
                CF = (A >= B);
                OF = ~((A[31] != B[31]) && (F[31] != A[31]));
            end
            4'd6: F = (A < B) ? 32'd1 : 32'd0;
            4'd7: F = B << A[4:0];
            default: F = 32'd0;
        endcase
        ZF = (F == 32'd0);
        SF = F[31];
        PF = ~^F;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic cond_ref(input logic [2:0] c, input logic [4:0] fl);
        logic z, cy, v, s;
        z = fl[4]; cy = fl[3]; v = fl[2]; s = fl[1];
        case (c)
            3'd0: return 1'b0;
            3'd1: return 1'b1;
            3'd2: return z;
            3'd3: return !z;
            3'd4: return s != v;
            3'd5: return s == v;
            3'd6: return !cy;
            default: return cy;
        endcase
    endfunction

    // Reference model from arithmetic definitions; e.psw is the PSW after this op.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] cond, input logic src, input logic set,
                                   input logic [4:0] psw_in);
        exp_t               e;
        longint             sr;
        longint unsigned    ur;
        logic [31:0]        f;
        logic               c, v;
        logic [4:0]         fl;
        e.a = a;
        e.b = b;
        e.op_drv = op[3] ? 4'd0 : op;
        if (op[3]) begin
            e.f = 32'd0; e.flags = 5'd0; e.taken = 1'b0; e.err = 1'b1; e.psw = psw_in;
            return e;
        end
        c = 1'b0; v = 1'b0; f = 32'd0; sr = 64'sd0; ur = 64'd0;
        case (op)
            4'd0: f = a & b;
            4'd1: f = a | b;
            4'd2: f = a ^ b;
            4'd3: f = ~(a | b);
            4'd4: begin
                ur = {32'd0, a} + {32'd0, b};
                f  = ur[31:0];
                c  = ur > 64'h0000_0000_FFFF_FFFF;
                sr = longint'($signed(a)) + longint'($signed(b));
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd5: begin
                f  = a - b;
                c  = (a >= b);
                sr = longint'($signed(a)) - longint'($signed(b));
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd6: f = (a < b) ? 32'd1 : 32'd0;
            default: f = b << (a % 32);
        endcase
        fl = {f == 32'd0, c, v, f[31], ($countones(f) % 2) == 0};
        e.f = f;
        e.flags = fl;
        e.err = 1'b0;
        e.taken = cond_ref(cond, src ? psw_in : fl);
        e.psw = set ? fl : psw_in;
        return e;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 8));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] cond, input logic src, input logic set);
        int   w;
        bit   done;
        exp_t e;
        w = 0;
        done = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        req_cond = cond; req_cond_src = src; req_set_flags = set;
        while (!done) begin
            #2;
            if (req_ready) begin
                e = model(op, a, b, cond, src, set, mpsw);
                mpsw = e.psw;
                q.push_back(e);
                @(posedge clk);
                #1 req_valid = 1'b0;
                done = 1;
            end else if (w >= 100) begin
                chk("req_ready_timeout", 64'(req_ready), 64'd1);
                req_valid = 1'b0;
                done = 1;
            end else begin
                w++;
                @(negedge clk);
            end
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("drain_timeout", 64'(q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Consumer ready pattern.
    initial begin
        resp_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rr_mode)
                0:       resp_ready = 1'b1;
                1:       resp_ready = ($urandom_range(0, 3) != 0);
                default: resp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares every retiring response against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && resp_valid && resp_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 64'(resp_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("resp_f", 64'(resp_f), 64'(e.f));
                    chk("resp_flags", 64'(resp_flags), 64'(e.flags));
                    chk("resp_taken", 64'(resp_taken), 64'(e.taken));
                    chk("resp_err", 64'(resp_err), 64'(e.err));
                    chk("psw", 64'(psw), 64'(e.psw));
                end
            end
        end
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        req_valid = 1'b0; req_op = 4'd0; req_a = 32'd0; req_b = 32'd0;
        req_cond = 3'd0; req_cond_src = 1'b0; req_set_flags = 1'b0;
        #12;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_op", 64'(OP), 64'd0);
        chk("rst_a", 64'(A), 64'd0);
        chk("rst_b", 64'(B), 64'd0);
        chk("rst_resp_f", 64'(resp_f), 64'd0);
        chk("rst_resp_flags", 64'(resp_flags), 64'd0);
        chk("rst_resp_taken", 64'(resp_taken), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_psw", 64'(psw), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: OP/A/B visible the cycle after accept, response the cycle after that.
        issue(4'd5, 32'd5, 32'd5, 3'd2, 1'b0, 1'b1);
        e = q[0];
        @(negedge clk); #2;
        chk("exec_op", 64'(OP), 64'(e.op_drv));
        chk("exec_a", 64'(A), 64'(e.a));
        chk("exec_b", 64'(B), 64'(e.b));
        chk("exec_no_resp", 64'(resp_valid), 64'd0);
        @(negedge clk); #2;
        chk("resp_latency", 64'(resp_valid), 64'd1);

        issue(4'd5, 32'd3, 32'd7, 3'd6, 1'b0, 1'b0);
        issue(4'd5, 32'd3, 32'd7, 3'd7, 1'b0, 1'b0);
        issue(4'd5, 32'h8000_0000, 32'd1, 3'd4, 1'b0, 1'b0);
        issue(4'd5, 32'hFFFF_FFFE, 32'd1, 3'd4, 1'b0, 1'b0);
        issue(4'b1010, 32'd12, 32'd34, 3'd1, 1'b0, 1'b1);
        @(negedge clk); #2;
        chk("illegal_op_drv", 64'(OP), 64'd0);
        issue(4'd5, 32'd9, 32'd9, 3'd0, 1'b0, 1'b1);
        issue(4'd4, 32'd1, 32'd2, 3'd2, 1'b1, 1'b1);
        drain();

        // Randomised traffic with a stalling consumer and idle gaps.
        rr_mode = 1;
        for (int i = 0; i < 300; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            issue(op, rnd_val(), rnd_val(), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rr_mode = 0;
        drain();

        // Indefinite stall, then reset while the response is held.
        rr_mode = 2;
        @(negedge clk);
        issue(4'd5, 32'd9, 32'd9, 3'd2, 1'b0, 1'b1);
        e = q[0];
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd4; req_a = 32'd1; req_b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("stall_req_ready", 64'(req_ready), 64'd0);
            chk("stall_resp_valid", 64'(resp_valid), 64'd1);
            chk("stall_resp_f", 64'(resp_f), 64'(e.f));
            chk("stall_op", 64'(OP), 64'(e.op_drv));
            if (i < 4) @(negedge clk);
        end
        chk("psw_before_rst", 64'(psw), 64'(e.psw));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_mid_psw", 64'(psw), 64'd0);
        chk("rst_mid_req_ready", 64'(req_ready), 64'd1);
        q.delete();
        mpsw = 5'd0;
        req_valid = 1'b0;
        rr_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            issue(4'($urandom_range(0, 15)), rnd_val(), rnd_val(), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
